// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshake bundle for decode_stage
// DECODE_ILLEGAL_TRAP_EN adds the o_illegal signal.
interface decode_stage_if #(
    parameter int WIDTH      = 32,
    parameter int ILEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  i_valid;
    logic                  o_ready;
    logic [ILEN-1:0]       i_instruction;
    logic [WIDTH-1:0]      i_pc;
    logic                  i_flush;
    logic                  o_valid;
    logic                  i_ready;
    logic [6:0]            o_opcode;
    logic [REG_ADDR_W-1:0] o_rd;
    logic [2:0]            o_funct3;
    logic [REG_ADDR_W-1:0] o_rs1;
    logic [REG_ADDR_W-1:0] o_rs2;
    logic [6:0]            o_funct7;
    logic [2:0]            o_fmt;
    logic [WIDTH-1:0]      o_imm;
    logic [WIDTH-1:0]      o_pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic                  o_illegal;
`endif

    modport slave (
        input  i_valid, i_instruction, i_pc, i_flush, i_ready,
        output o_ready, o_valid, o_opcode, o_rd, o_funct3, o_rs1, o_rs2,
               o_funct7, o_fmt, o_imm, o_pc
`ifdef DECODE_ILLEGAL_TRAP_EN
        , output o_illegal
`endif
    );

    modport master (
        output i_valid, i_instruction, i_pc, i_flush, i_ready,
        input  o_ready, o_valid, o_opcode, o_rd, o_funct3, o_rs1, o_rs2,
               o_funct7, o_fmt, o_imm, o_pc
`ifdef DECODE_ILLEGAL_TRAP_EN
        , input o_illegal
`endif
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with 2-entry skid buffer
// Optional DECODE_ILLEGAL_TRAP_EN registers an illegal-instruction flag with each entry.
module decode_stage #(
    parameter int WIDTH      = 32,
    parameter int ILEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    decode_stage_if.slave bus
);
    if (ILEN != 32) begin : g_bad_ilen
        $error("decode_stage: ILEN must be 32");
    end

    localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                           FMT_U = 3'd4, FMT_J = 3'd5, FMT_X = 3'd7;

    typedef struct packed {
        logic [6:0]            opcode;
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [6:0]            funct7;
        logic [2:0]            fmt;
        logic [WIDTH-1:0]      imm;
        logic [WIDTH-1:0]      pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic                  illegal;
`endif
    } entry_t;

    entry_t main_q, main_d, skid_q, skid_d, dec;
    logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic   in_fire, out_fire;
    logic [31:0] instr, imm32;

    assign instr = bus.i_instruction[31:0];

    // Decode is done once on the way in; skid holds already-decoded entries.
    always_comb begin
        dec        = '0;
        imm32      = '0;
        dec.opcode = instr[6:0];
        dec.rd     = REG_ADDR_W'(instr[11:7]);
        dec.funct3 = instr[14:12];
        dec.rs1    = REG_ADDR_W'(instr[19:15]);
        dec.rs2    = REG_ADDR_W'(instr[24:20]);
        dec.funct7 = instr[31:25];
        dec.pc     = bus.i_pc;
        case (instr[6:0])
            7'b0110011:                                     dec.fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111:                         dec.fmt = FMT_I;
            7'b0100011:                                     dec.fmt = FMT_S;
            7'b1100011:                                     dec.fmt = FMT_B;
            7'b0110111, 7'b0010111:                         dec.fmt = FMT_U;
            7'b1101111:                                     dec.fmt = FMT_J;
            default:                                        dec.fmt = FMT_X;
        endcase
        case (dec.fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        dec.imm        = {WIDTH{imm32[31]}};
        dec.imm[31:0]  = imm32;
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec.illegal = (dec.fmt == FMT_X) || (instr[1:0] != 2'b11)
            || ((dec.fmt == FMT_R) && (instr[31:25] != 7'b0000000) && (instr[31:25] != 7'b0100000))
            || ((instr[6:0] == 7'b0010011) && (instr[14:12] == 3'b001) && (instr[31:25] != 7'b0000000))
            || ((instr[6:0] == 7'b0010011) && (instr[14:12] == 3'b101)
                && (instr[31:25] != 7'b0000000) && (instr[31:25] != 7'b0100000));
`endif
    end

    assign in_fire  = bus.i_valid && !skid_valid_q;
    assign out_fire = main_valid_q && bus.i_ready;

    // Skid is only ever filled while main is full, so main-empty implies skid-empty.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (bus.i_flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.o_ready  = !skid_valid_q;
    assign bus.o_valid  = main_valid_q;
    assign bus.o_opcode = main_q.opcode;
    assign bus.o_rd     = main_q.rd;
    assign bus.o_funct3 = main_q.funct3;
    assign bus.o_rs1    = main_q.rs1;
    assign bus.o_rs2    = main_q.rs2;
    assign bus.o_funct7 = main_q.funct7;
    assign bus.o_fmt    = main_q.fmt;
    assign bus.o_imm    = main_q.imm;
    assign bus.o_pc     = main_q.pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign bus.o_illegal = main_q.illegal;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.WIDTH(32)) bus ();
    decode_stage_if #(.WIDTH(64)) bus64 ();

    decode_stage #(.WIDTH(32)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
    decode_stage #(.WIDTH(64)) dut64 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus64.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_valid = 0; bus.i_instruction = '0; bus.i_pc = '0; bus.i_flush = 0; bus.i_ready = 1;
        bus64.i_valid = 0; bus64.i_instruction = '0; bus64.i_pc = '0; bus64.i_flush = 0; bus64.i_ready = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #12;
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_handshake: valid=%b ready=%b, required 0/1", bus.o_valid, bus.o_ready);
        end
        n_checks++;
        if (bus.o_imm !== 32'h0 || bus.o_pc !== 32'h0 || bus.o_fmt !== 3'd0 || bus.o_rd !== 5'd0) begin
            n_fail++; $display("FAIL reset_data: imm=%h pc=%h fmt=%0d rd=%0d, required all 0", bus.o_imm, bus.o_pc, bus.o_fmt, bus.o_rd);
        end
        #3 rst_n = 1;
        step();
    endtask

    task automatic test_formats();
        logic [31:0] ins  [8] = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h123452B7,
                                  32'hFFDFF0EF, 32'h002081B3, 32'h0000007F, 32'h7FF00093};
        logic [2:0]  efmt [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd7, 3'd1};
        logic [4:0]  erd  [8] = '{5'd1, 5'd8, 5'd29, 5'd5, 5'd1, 5'd3, 5'd0, 5'd1};
        logic [4:0]  ers1 [8] = '{5'd0, 5'd1, 5'd0, 5'd8, 5'd31, 5'd1, 5'd0, 5'd0};
        logic [4:0]  ers2 [8] = '{5'd31, 5'd2, 5'd0, 5'd3, 5'd29, 5'd2, 5'd0, 5'd31};
        logic [2:0]  ef3  [8] = '{3'd0, 3'd2, 3'd0, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0};
        logic [6:0]  ef7  [8] = '{7'h7F, 7'h00, 7'h7F, 7'h09, 7'h7F, 7'h00, 7'h00, 7'h3F};
        logic [31:0] eimm [8] = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC, 32'h12345000,
                                  32'hFFFFFFFC, 32'h00000000, 32'h00000000, 32'h000007FF};
        bus.i_ready = 1;
        for (int i = 0; i < 8; i++) begin
            bus.i_valid = 1;
            bus.i_instruction = ins[i];
            bus.i_pc = 32'h100 + 32'(4 * i);
            step();
            n_checks++;
            if (bus.o_valid !== 1'b1 || bus.o_fmt !== efmt[i] || bus.o_pc !== 32'h100 + 32'(4 * i)) begin
                n_fail++; $display("FAIL fmt[%0d]: valid=%b fmt=%0d pc=%h, required 1/%0d/%h",
                                   i, bus.o_valid, bus.o_fmt, bus.o_pc, efmt[i], 32'h100 + 32'(4 * i));
            end
            n_checks++;
            if (bus.o_rd !== erd[i] || bus.o_rs1 !== ers1[i] || bus.o_rs2 !== ers2[i]
                || bus.o_funct3 !== ef3[i] || bus.o_funct7 !== ef7[i]) begin
                n_fail++; $display("FAIL fields[%0d]: rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h, required %0d/%0d/%0d/%0d/%h",
                                   i, bus.o_rd, bus.o_rs1, bus.o_rs2, bus.o_funct3, bus.o_funct7,
                                   erd[i], ers1[i], ers2[i], ef3[i], ef7[i]);
            end
            n_checks++;
            if (bus.o_imm !== eimm[i]) begin
                n_fail++; $display("FAIL imm[%0d]: got %h, required %h", i, bus.o_imm, eimm[i]);
            end
        end
        bus.i_valid = 0;
        step();
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_imm !== 32'h000007FF) begin
            n_fail++; $display("FAIL hold_after_drain: valid=%b imm=%h, required 0/000007ff", bus.o_valid, bus.o_imm);
        end
    endtask

    task automatic test_width64();
        bus64.i_valid = 1;
        bus64.i_instruction = 32'hFFF00093;
        bus64.i_pc = 64'h1_0000_0100;
        bus64.i_ready = 1;
        step();
        bus64.i_valid = 0;
        n_checks++;
        if (bus64.o_valid !== 1'b1 || bus64.o_imm !== 64'hFFFF_FFFF_FFFF_FFFF || bus64.o_pc !== 64'h1_0000_0100) begin
            n_fail++; $display("FAIL width64: valid=%b imm=%h pc=%h, required 1/ffffffffffffffff/0000000100000100",
                               bus64.o_valid, bus64.o_imm, bus64.o_pc);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
        int sent = 0, got = 0;
        bit ready_checked = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            bus.i_valid = (sent < 4);
            bus.i_instruction = (sent < 4) ? ins[sent] : 32'h0;
            bus.i_pc = 32'h200 + 32'(4 * sent);
            bus.i_ready = (cyc >= 3);
            #1;
            if (bus.o_valid && bus.i_ready) begin
                n_checks++;
                if (bus.o_pc !== 32'h200 + 32'(4 * got) || bus.o_rd !== 5'(got + 1)) begin
                    n_fail++; $display("FAIL b2b_out[%0d]: pc=%h rd=%0d, required %h/%0d",
                                       got, bus.o_pc, bus.o_rd, 32'h200 + 32'(4 * got), got + 1);
                end
                got++;
            end
            if (bus.i_valid && bus.o_ready) sent++;
            step();
            if (sent == 2 && !ready_checked) begin
                ready_checked = 1;
                n_checks++;
                if (bus.o_ready !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_ready_drop: o_ready=%b, required 0", bus.o_ready);
                end
            end
        end
        bus.i_valid = 0;
        n_checks++;
        if (got != 4) begin
            n_fail++; $display("FAIL b2b_count: got %0d results, required 4", got);
        end
        step();
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_no_dup: valid=%b ready=%b, required 0/1", bus.o_valid, bus.o_ready);
        end
    endtask

    task automatic fill_two(input logic [31:0] pc0);
        bus.i_ready = 0;
        bus.i_valid = 1;
        bus.i_instruction = 32'h00500293; bus.i_pc = pc0;
        step();
        bus.i_instruction = 32'h00600313; bus.i_pc = pc0 + 4;
        step();
    endtask

    task automatic test_flush();
        fill_two(32'h300);
        n_checks++;
        if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b1) begin
            n_fail++; $display("FAIL flush_setup: ready=%b valid=%b, required 0/1", bus.o_ready, bus.o_valid);
        end
        bus.i_instruction = 32'h00700393; bus.i_pc = 32'h308;
        bus.i_flush = 1;
        step();
        bus.i_flush = 0;
        bus.i_valid = 0;
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_full: valid=%b ready=%b, required 0/1", bus.o_valid, bus.o_ready);
        end
        bus.i_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus.o_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_residue[%0d]: valid=%b pc=%h, required valid 0", i, bus.o_valid, bus.o_pc);
            end
        end
        bus.i_ready = 0;
        bus.i_valid = 1; bus.i_instruction = 32'h00800413; bus.i_pc = 32'h400;
        step();
        bus.i_instruction = 32'h00900493; bus.i_pc = 32'h404;
        bus.i_flush = 1;
        step();
        bus.i_flush = 0; bus.i_valid = 0; bus.i_ready = 1;
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_drop_input: valid=%b ready=%b pc=%h, required 0/1", bus.o_valid, bus.o_ready, bus.o_pc);
        end
        step();
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_drop_late: valid=%b pc=%h, required 0", bus.o_valid, bus.o_pc);
        end
    endtask

    task automatic test_reset_midstream();
        fill_two(32'h500);
        bus.i_valid = 0;
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_pc !== 32'h0 || bus.o_imm !== 32'h0) begin
            n_fail++; $display("FAIL reset_midstream: valid=%b ready=%b pc=%h imm=%h, required 0/1/0/0",
                               bus.o_valid, bus.o_ready, bus.o_pc, bus.o_imm);
        end
        #3 rst_n = 1;
        bus.i_ready = 1;
        step();
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: valid=%b, required 0", bus.o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_width64();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32I instruction-decode pipeline stage, successor to the combinational field splitter. It accepts a fetched instruction and PC through a valid/ready handshake and extracts every field (rd, rs1, rs2, funct3, funct7). It generates the sign-extended immediate for all six RV32I formats and presents results one cycle later, with a 2-entry skid buffer so fetch never stalls combinationally on execute backpressure. It sits between the fetch stage and register-file read / execute.

Parameters:
WIDTH, 32, datapath width of PC and immediate (32 or 64); immediates are sign-extended to WIDTH
ILEN, 32, instruction width; fixed at 32, any other value is a elaboration error
REG_ADDR_W, 5, register-index width

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  upstream instruction valid
o_ready  output  1  stage can accept an instruction this cycle
i_instruction  input  ILEN  raw instruction
i_pc  input  WIDTH  PC of i_instruction
i_flush  input  1  discard all held and incoming instructions
o_valid  output  1  decoded result valid
i_ready  input  1  downstream accepts result
o_opcode  output  7  instr[6:0]
o_rd  output  REG_ADDR_W  instr[11:7]
o_funct3  output  3  instr[14:12]
o_rs1  output  REG_ADDR_W  instr[19:15]
o_rs2  output  REG_ADDR_W  instr[24:20]
o_funct7  output  7  instr[31:25]
o_fmt  output  3  0=R 1=I 2=S 3=B 4=U 5=J 7=unknown
o_imm  output  WIDTH  sign-extended immediate (0 for R and unknown)
o_pc  output  WIDTH  PC travelling with the instruction
o_illegal  output  1  illegal-instruction flag (only with DECODE_ILLEGAL_TRAP_EN)

Behaviour:
- Reset (async assert, sync release): both buffer entries invalid; o_valid=0, o_ready=1, all data outputs 0.
- Input transfer when i_valid&&o_ready; output transfer when o_valid&&i_ready.
- Latency: instruction accepted in cycle N appears on outputs in cycle N+1 if output slot empty or draining.
- Storage: output register (main) + skid register. o_ready = !skid_valid, driven from a flop, no combinational path from i_ready.
- Main empty or draining: accepted instr goes to main. Main full and not draining: accepted instr goes to skid. Main drains with skid full: skid moves to main, skid empties. Strict in-order, no loss, no duplication.
- Simultaneous accept + drain with skid empty: main loads new instr, o_valid stays 1.
- Decode performed combinationally at input and stored decoded (no re-decode from skid).
- Format by opcode: 0110011 R; 0010011/0000011/1100111/1110011/0001111 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; else unknown.
- Immediates: I={instr[31:20]}; S={[31:25],[11:7]}; B={[31],[7],[30:25],[11:8],0}; U={[31:12],12'b0}; J={[31],[19:12],[20],[30:21],0}; all sign-extended from instr[31] to WIDTH.
- i_flush: next edge clears both valids; any same-cycle input transfer is dropped; o_ready=1 the cycle after. Flush wins over every other event.
- Data outputs hold last value when o_valid=0 (not cleared) except on reset.

Optional Feature:
DECODE_ILLEGAL_TRAP_EN: defined -> o_illegal registered alongside the entry, set for fmt unknown, instr[1:0]!=11, R-type with funct7 not in {0000000,0100000}, or SLLI/SRLI/SRAI with bad funct7; illegal instructions still flow through the buffer. Undefined -> o_illegal port absent, no checks, unknown opcodes pass with o_fmt=7.

Test Plan:
- Reset mid-stream with 2 entries held -> o_valid=0, o_ready=1, outputs 0 immediately on i_rst_n low.
- 0xFFF00093 (addi x1,x0,-1), pc 0x100 -> next cycle o_fmt=1, o_rd=1, o_rs1=0, o_imm=0xFFFFFFFF, o_pc=0x100.
- 0x0020A423 (sw x2,8(x1)) -> o_fmt=2, o_rs1=1, o_rs2=2, o_imm=0x00000008; 0xFE000EE3 (beq -4) -> o_fmt=3, o_imm=0xFFFFFFFC.
- 0x123452B7 (lui x5) -> o_fmt=4, o_rd=5, o_imm=0x12345000; WIDTH=64 rerun of addi -1 -> o_imm=0xFFFFFFFFFFFFFFFF.
- Stream 4 instrs back-to-back, i_ready=0 for 3 cycles -> o_ready drops after 2nd accept, all 4 emerge in order once i_ready=1, none lost/duplicated.
- i_flush with both entries full and i_valid=1 -> next cycle o_valid=0, o_ready=1, flushed and same-cycle instr never appear.
